seq_mult_ctrl: RTL and testbench



---
 rtl/seq_mult_ctrl_if.sv | 14 +
 rtl/seq_mult_ctrl.sv | 94 +++++++++
 tb/tb_seq_mult_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_ctrl_if.sv
// Operand/start request and busy/done/product response bundle for seq_mult_ctrl.
interface seq_mult_ctrl_if #(
    parameter int WIDTH = 5
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   q;

    modport master (output start, a, b, input busy, done, q);
    modport slave  (input start, a, b, output busy, done, q);
endinterface

// File: rtl/seq_mult_ctrl.sv
// Shift-and-add unsigned multiplier: one shared 2*WIDTH-bit adder, WIDTH RUN cycles per product.
module seq_mult_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst,
    seq_mult_ctrl_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PW-1:0]      sum;

    // The single shared adder; also supplies the final product on the last iteration.
    always_comb begin
        sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    prod_d  = sum;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered copies of the next-state decode, so nothing combinational reaches the pins.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.q    = prod_q;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Self-checking bench for seq_mult_ctrl: per-cycle transaction model plus directed literal checks.
module tb_seq_mult_ctrl;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_mult_ctrl_if #(.WIDTH(W)) smi ();

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (smi)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int done_count = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: edges elapsed since acceptance, -1 when idle.
    int ph = -1;
    int pend = 0;
    int mq = 0;
    always @(posedge clk) begin
        if (rst) begin
            ph = -1;
            mq = 0;
        end else if (ph < 0) begin
            if (smi.start) begin
                ph = 0;
                pend = int'(smi.a) * int'(smi.b);
            end
        end else if (ph == W) begin
            ph = -1;
        end else begin
            ph++;
            if (ph == W) mq = pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", longint'(smi.busy), longint'(ph >= 0));
            chk("model_done", longint'(smi.done), longint'(ph == W));
            chk("model_q", longint'(smi.q), longint'(mq));
        end
        if (smi.done === 1'b1) done_count++;
    end

    task automatic wait_idle();
        int k;
        for (k = 0; k < 4 * W + 10; k++) begin
            @(negedge clk);
            if (!smi.busy) break;
        end
        if (k >= 4 * W + 10) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int qv, output int lat, output int bc);
        bit got;
        wait_idle();
        smi.a = av;
        smi.b = bv;
        smi.start = 1'b1;
        @(posedge clk);
        #1 smi.start = 1'b0;
        smi.a = W'($urandom);
        smi.b = W'($urandom);
        lat = 0; bc = 0; got = 1'b0; qv = -1;
        for (int k = 0; k < 3 * W + 10; k++) begin
            @(negedge clk);
            if (smi.busy) bc++;
            if (smi.done) begin
                got = 1'b1;
                qv = int'(smi.q);
                break;
            end
            lat++;
        end
        if (!got) chk("done_timeout", 0, 1);
        @(negedge clk);
        if (smi.busy) bc++;
    endtask

    int qv, lat, bc, dc0, t1, t2, q1, q2, nd;

    initial begin
        smi.start = 1'b1;
        smi.a = 5'd31;
        smi.b = 5'd31;
        rst = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_q", smi.q, 0);
        chk("rst_busy", smi.busy, 0);
        chk("rst_done", smi.done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        smi.start = 1'b0;

        run_op(5'd31, 5'd31, qv, lat, bc);
        chk("q_31x31", qv, 961);
        chk("lat_31x31", lat, 5);
        chk("busy_cycles_31x31", bc, 6);
        run_op(5'd0, 5'd17, qv, lat, bc);
        chk("q_0x17", qv, 0);
        chk("lat_0x17", lat, 5);
        run_op(5'd19, 5'd1, qv, lat, bc);
        chk("q_19x1", qv, 19);

        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                run_op(W'(i), W'(j), qv, lat, bc);
                chk("sweep_q", qv, i * j);
            end
        end

        // Operand and start isolation
        wait_idle();
        dc0 = done_count;
        smi.a = 5'd6; smi.b = 5'd7; smi.start = 1'b1;
        @(posedge clk);
        #1 smi.a = 5'd3; smi.b = 5'd3;
        repeat (6) @(posedge clk);
        #1 smi.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("iso_q", smi.q, 42);
        chk("iso_done_count", done_count - dc0, 1);

        // Reset mid-operation
        wait_idle();
        smi.a = 5'd25; smi.b = 5'd9; smi.start = 1'b1;
        @(posedge clk);
        #1 smi.start = 1'b0;
        dc0 = done_count;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", smi.busy, 0);
        chk("abort_q", smi.q, 0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_count - dc0, 0);
        run_op(5'd2, 5'd3, qv, lat, bc);
        chk("after_abort_q", qv, 6);

        // Back-to-back with start held
        wait_idle();
        smi.a = 5'd5; smi.b = 5'd4; smi.start = 1'b1;
        @(posedge clk);
        #1 smi.a = 5'd7; smi.b = 5'd7;
        nd = 0; t1 = 0; t2 = 0; q1 = -1; q2 = -1;
        for (int k = 0; k < 40 && nd < 2; k++) begin
            @(negedge clk);
            if (smi.done) begin
                if (nd == 0) begin t1 = k; q1 = int'(smi.q); end
                else begin t2 = k; q2 = int'(smi.q); end
                nd++;
            end
        end
        smi.start = 1'b0;
        chk("b2b_done_seen", nd, 2);
        chk("b2b_q1", q1, 20);
        chk("b2b_q2", q2, 49);
        chk("b2b_spacing", t2 - t1, 7);

        // Randomized traffic, including occasional resets, against the model
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            smi.start = ($urandom_range(0, 2) == 0);
            smi.a = W'($urandom);
            smi.b = W'($urandom);
            rst = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        smi.start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
